lcd_timing_gen: RTL and testbench

- Parametrised, dual-profile RGB LCD timing generator; successor to the fixed 800x480 DE-mode driver.
- Produces real HS/VS pulses with configurable polarity alongside DE.
- Requests pixels a parametrised number of clocks ahead of DE so upstream character/ROM pipelines of any depth can keep up.
- Adds frame/line markers and glitch-free panel-profile switching at frame boundaries. Sits between the pixel-source (character renderer) and the panel pins.

---
 rtl/lcd_timing_pkg.sv | 48 ++++
 rtl/lcd_sync_counter.sv | 33 +++
 rtl/lcd_timing_gen.sv | 171 +++++++++++++++++
 tb/tb_lcd_timing_gen.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_timing_pkg.sv
// Shared types and constants for lcd_timing_gen: panel profile record,
// the two default panel profiles and the colour-bar palette.
package lcd_timing_pkg;

    typedef struct packed {
        int unsigned h_sync;
        int unsigned h_back;
        int unsigned h_disp;
        int unsigned h_total;
        int unsigned v_sync;
        int unsigned v_back;
        int unsigned v_disp;
        int unsigned v_total;
    } profile_t;

    localparam profile_t PROFILE_800X480 = '{
        h_sync: 128, h_back: 88, h_disp: 800, h_total: 1056,
        v_sync: 2,   v_back: 33, v_disp: 480, v_total: 525
    };

    localparam profile_t PROFILE_480X272 = '{
        h_sync: 41, h_back: 2, h_disp: 480, h_total: 525,
        v_sync: 10, v_back: 2, v_disp: 272, v_total: 286
    };

    localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
    localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
    localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] BAR_RED     = 24'hFF0000;
    localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
    localparam logic [23:0] BAR_BLACK   = 24'h000000;

    function automatic logic [23:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    return BAR_WHITE;
            3'd1:    return BAR_YELLOW;
            3'd2:    return BAR_CYAN;
            3'd3:    return BAR_GREEN;
            3'd4:    return BAR_MAGENTA;
            3'd5:    return BAR_RED;
            3'd6:    return BAR_BLUE;
            default: return BAR_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/lcd_sync_counter.sv
// Horizontal/vertical position counters with wrap and a last-clock-of-frame strobe.
module lcd_sync_counter #(
    parameter int unsigned CNT_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] h_total,
    input  logic [CNT_W-1:0] v_total,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             frame_end
);

    logic h_last;
    logic v_last;

    assign h_last    = (h_cnt == h_total - 1'b1);
    assign v_last    = (v_cnt == v_total - 1'b1);
    assign frame_end = h_last && v_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/lcd_timing_gen.sv
// Dual-profile RGB LCD timing generator with lead-ahead pixel requests.
// Optional colour-bar source enabled by defining LCD_TEST_PATTERN_EN.
module lcd_timing_gen
    import lcd_timing_pkg::*;
#(
    parameter int unsigned CNT_W     = 12,
    parameter int unsigned DATA_W    = 24,
    parameter int unsigned REQ_LEAD  = 2,
    parameter bit          HS_POL    = 1'b0,
    parameter bit          VS_POL    = 1'b0,
    parameter int unsigned P0_H_SYNC  = PROFILE_800X480.h_sync,
    parameter int unsigned P0_H_BACK  = PROFILE_800X480.h_back,
    parameter int unsigned P0_H_DISP  = PROFILE_800X480.h_disp,
    parameter int unsigned P0_H_TOTAL = PROFILE_800X480.h_total,
    parameter int unsigned P0_V_SYNC  = PROFILE_800X480.v_sync,
    parameter int unsigned P0_V_BACK  = PROFILE_800X480.v_back,
    parameter int unsigned P0_V_DISP  = PROFILE_800X480.v_disp,
    parameter int unsigned P0_V_TOTAL = PROFILE_800X480.v_total,
    parameter int unsigned P1_H_SYNC  = PROFILE_480X272.h_sync,
    parameter int unsigned P1_H_BACK  = PROFILE_480X272.h_back,
    parameter int unsigned P1_H_DISP  = PROFILE_480X272.h_disp,
    parameter int unsigned P1_H_TOTAL = PROFILE_480X272.h_total,
    parameter int unsigned P1_V_SYNC  = PROFILE_480X272.v_sync,
    parameter int unsigned P1_V_BACK  = PROFILE_480X272.v_back,
    parameter int unsigned P1_V_DISP  = PROFILE_480X272.v_disp,
    parameter int unsigned P1_V_TOTAL = PROFILE_480X272.v_total
) (
    input  logic              lcd_pclk,
    input  logic              rst,
    input  logic              mode_sel,
    input  logic              test_pat_en,
    input  logic [DATA_W-1:0] pixel_data,
    output logic [CNT_W-1:0]  pixel_xpos,
    output logic [CNT_W-1:0]  pixel_ypos,
    output logic [CNT_W-1:0]  h_disp,
    output logic [CNT_W-1:0]  v_disp,
    output logic              active_mode,
    output logic              data_req,
    output logic              frame_start,
    output logic              line_start,
    output logic              lcd_de,
    output logic              lcd_hs,
    output logic              lcd_vs,
    output logic              lcd_bl,
    output logic              lcd_clk,
    output logic              lcd_rst,
    output logic [DATA_W-1:0] lcd_rgb
);

    localparam profile_t PROF0 = '{
        h_sync: P0_H_SYNC, h_back: P0_H_BACK, h_disp: P0_H_DISP, h_total: P0_H_TOTAL,
        v_sync: P0_V_SYNC, v_back: P0_V_BACK, v_disp: P0_V_DISP, v_total: P0_V_TOTAL
    };
    localparam profile_t PROF1 = '{
        h_sync: P1_H_SYNC, h_back: P1_H_BACK, h_disp: P1_H_DISP, h_total: P1_H_TOTAL,
        v_sync: P1_V_SYNC, v_back: P1_V_BACK, v_disp: P1_V_DISP, v_total: P1_V_TOTAL
    };

    // The lead subtraction below relies on REQ_LEAD never exceeding the sync+back porch.
    if (REQ_LEAD == 0 || REQ_LEAD > 8 ||
        REQ_LEAD > P0_H_SYNC + P0_H_BACK || REQ_LEAD > P1_H_SYNC + P1_H_BACK) begin : g_bad_lead
        $error("lcd_timing_gen: REQ_LEAD must be 1..8 and not exceed H_SYNC+H_BACK");
    end

    logic             mode;
    logic             frame_end;
    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic [CNT_W-1:0] h_sync_l, h_back_l, h_disp_l, h_total_l;
    logic [CNT_W-1:0] v_sync_l, v_back_l, v_disp_l, v_total_l;
    logic [CNT_W-1:0] ha, va, req_lo;
    logic             v_act, h_req, h_de;

    assign h_sync_l  = mode ? CNT_W'(PROF1.h_sync)  : CNT_W'(PROF0.h_sync);
    assign h_back_l  = mode ? CNT_W'(PROF1.h_back)  : CNT_W'(PROF0.h_back);
    assign h_disp_l  = mode ? CNT_W'(PROF1.h_disp)  : CNT_W'(PROF0.h_disp);
    assign h_total_l = mode ? CNT_W'(PROF1.h_total) : CNT_W'(PROF0.h_total);
    assign v_sync_l  = mode ? CNT_W'(PROF1.v_sync)  : CNT_W'(PROF0.v_sync);
    assign v_back_l  = mode ? CNT_W'(PROF1.v_back)  : CNT_W'(PROF0.v_back);
    assign v_disp_l  = mode ? CNT_W'(PROF1.v_disp)  : CNT_W'(PROF0.v_disp);
    assign v_total_l = mode ? CNT_W'(PROF1.v_total) : CNT_W'(PROF0.v_total);

    assign ha     = h_sync_l + h_back_l;
    assign va     = v_sync_l + v_back_l;
    assign req_lo = ha - CNT_W'(REQ_LEAD);
    assign v_act  = (v_cnt >= va) && (v_cnt < va + v_disp_l);
    assign h_req  = (h_cnt >= req_lo) && (h_cnt < req_lo + h_disp_l);
    assign h_de   = (h_cnt >= ha) && (h_cnt < ha + h_disp_l);

    lcd_sync_counter #(.CNT_W(CNT_W)) u_sync_counter (
        .clk      (lcd_pclk),
        .rst      (rst),
        .h_total  (h_total_l),
        .v_total  (v_total_l),
        .h_cnt    (h_cnt),
        .v_cnt    (v_cnt),
        .frame_end(frame_end)
    );

    // mode flips on the last frame clock so the counters restart at 0,0 with the
    // new limits; the registered outputs then change on the frame_start clock.
    always_ff @(posedge lcd_pclk or posedge rst) begin
        if (rst) begin
            mode        <= 1'b0;
            active_mode <= 1'b0;
            h_disp      <= CNT_W'(PROF0.h_disp);
            v_disp      <= CNT_W'(PROF0.v_disp);
            data_req    <= 1'b0;
            lcd_de      <= 1'b0;
            pixel_xpos  <= '0;
            pixel_ypos  <= '0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
            lcd_hs      <= ~HS_POL;
            lcd_vs      <= ~VS_POL;
        end else begin
            if (frame_end) begin
                mode <= mode_sel;
            end
            active_mode <= mode;
            h_disp      <= h_disp_l;
            v_disp      <= v_disp_l;
            data_req    <= v_act && h_req;
            lcd_de      <= v_act && h_de;
            pixel_xpos  <= (v_act && h_req) ? h_cnt - req_lo : '0;
            pixel_ypos  <= v_act ? v_cnt - va : '0;
            frame_start <= (h_cnt == '0) && (v_cnt == '0);
            line_start  <= (h_cnt == '0);
            lcd_hs      <= (h_cnt < h_sync_l) ? HS_POL : ~HS_POL;
            lcd_vs      <= (v_cnt < v_sync_l) ? VS_POL : ~VS_POL;
        end
    end

    assign lcd_bl  = 1'b1;
    assign lcd_clk = lcd_pclk;
    assign lcd_rst = ~rst;

`ifdef LCD_TEST_PATTERN_EN
    logic [CNT_W-1:0] bar_w, seg_cnt;
    logic [2:0]       bar_idx;

    assign bar_w = h_disp >> 3;

    // Bar index saturates at the last (black) bar, which absorbs the remainder.
    always_ff @(posedge lcd_pclk or posedge rst) begin
        if (rst) begin
            seg_cnt <= '0;
            bar_idx <= '0;
        end else if (line_start) begin
            seg_cnt <= '0;
            bar_idx <= '0;
        end else if (lcd_de) begin
            if (seg_cnt == bar_w - 1'b1) begin
                seg_cnt <= '0;
                if (bar_idx != 3'd7) begin
                    bar_idx <= bar_idx + 1'b1;
                end
            end else begin
                seg_cnt <= seg_cnt + 1'b1;
            end
        end
    end

    assign lcd_rgb = !lcd_de    ? '0 :
                     test_pat_en ? DATA_W'(bar_color(bar_idx)) : pixel_data;
`else
    logic unused_test_pat;
    assign unused_test_pat = test_pat_en;
    assign lcd_rgb = lcd_de ? pixel_data : '0;
`endif

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Self-checking bench for lcd_timing_gen: default 800x480 instance plus a scaled
// two-profile instance (REQ_LEAD=5, active-high syncs). Honours LCD_TEST_PATTERN_EN.
module tb_lcd_timing_gen;

    localparam int unsigned CW     = 12;
    localparam int unsigned DW     = 24;
    localparam int unsigned S_LEAD = 5;

    typedef struct {
        logic        mode;
        int unsigned clocks;
        int unsigned lines;
        int unsigned de;
        int unsigned rows;
        int unsigned hs;
        int unsigned vs;
        int unsigned hd;
        int unsigned vd;
    } prof_vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    logic          rst_a = 1'b0, mode_a = 1'b0, tp_a = 1'b0;
    logic [DW-1:0] pix_a = 24'hA5C3E1;
    logic [CW-1:0] a_xpos, a_ypos, a_hd, a_vd;
    logic          a_mode, a_req, a_fs, a_ls, a_de, a_hs, a_vs, a_bl, a_clk, a_rst;
    logic [DW-1:0] a_rgb;

    logic          rst_s = 1'b0, mode_s = 1'b0, tp_s = 1'b0;
    logic [DW-1:0] pix_s = 24'h123456;
    logic [CW-1:0] s_xpos, s_ypos, s_hd, s_vd;
    logic          s_mode, s_req, s_fs, s_ls, s_de, s_hs, s_vs, s_bl, s_clk, s_rst;
    logic [DW-1:0] s_rgb;

    lcd_timing_gen dut (
        .lcd_pclk(clk), .rst(rst_a), .mode_sel(mode_a), .test_pat_en(tp_a),
        .pixel_data(pix_a), .pixel_xpos(a_xpos), .pixel_ypos(a_ypos),
        .h_disp(a_hd), .v_disp(a_vd), .active_mode(a_mode), .data_req(a_req),
        .frame_start(a_fs), .line_start(a_ls), .lcd_de(a_de), .lcd_hs(a_hs),
        .lcd_vs(a_vs), .lcd_bl(a_bl), .lcd_clk(a_clk), .lcd_rst(a_rst), .lcd_rgb(a_rgb)
    );

    lcd_timing_gen #(
        .REQ_LEAD(S_LEAD), .HS_POL(1'b1), .VS_POL(1'b1),
        .P0_H_SYNC(8), .P0_H_BACK(4), .P0_H_DISP(20), .P0_H_TOTAL(40),
        .P0_V_SYNC(2), .P0_V_BACK(3), .P0_V_DISP(6),  .P0_V_TOTAL(14),
        .P1_H_SYNC(4), .P1_H_BACK(3), .P1_H_DISP(12), .P1_H_TOTAL(24),
        .P1_V_SYNC(1), .P1_V_BACK(2), .P1_V_DISP(4),  .P1_V_TOTAL(9)
    ) dut_s (
        .lcd_pclk(clk), .rst(rst_s), .mode_sel(mode_s), .test_pat_en(tp_s),
        .pixel_data(pix_s), .pixel_xpos(s_xpos), .pixel_ypos(s_ypos),
        .h_disp(s_hd), .v_disp(s_vd), .active_mode(s_mode), .data_req(s_req),
        .frame_start(s_fs), .line_start(s_ls), .lcd_de(s_de), .lcd_hs(s_hs),
        .lcd_vs(s_vs), .lcd_bl(s_bl), .lcd_clk(s_clk), .lcd_rst(s_rst), .lcd_rgb(s_rgb)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    function automatic logic [23:0] pat_exp(input int unsigned px);
`ifdef LCD_TEST_PATTERN_EN
        return bars[(px / 100 > 7) ? 7 : px / 100];
`else
        return pix_a;
`endif
    endfunction

    task automatic wait_fs_s();
        int unsigned n = 0;
        while (!s_fs && n < 1000) begin
            step();
            n++;
        end
        check("s_wait_frame_start", {31'd0, s_fs}, 1);
    endtask

    // Measures one whole frame of dut_s, starting on a frame_start clock.
    task automatic measure(input prof_vec_t v, input string tag);
        int unsigned n = 0, lines = 0, de = 0, rows = 0, hs = 0, vs = 0;
        int unsigned reqrows = 0, xc = 0, t_req = 0;
        int unsigned lead_bad = 0, pos_bad = 0, rgb_bad = 0, hs_miss = 0;
        logic prev_req = 1'b0, prev_de = 1'b0;
        logic [CW-1:0] hd, vd;
        logic m;
        hd = s_hd;
        vd = s_vd;
        m  = s_mode;
        do begin
            if (s_ls) begin
                lines++;
                if (!s_hs) hs_miss++;
            end
            if (s_hs) hs++;
            if (s_vs) vs++;
            if (s_de) de++;
            if (s_req && !prev_req) begin
                t_req = n;
                xc = 0;
                reqrows++;
            end
            if (s_req) begin
                if (s_xpos != CW'(xc) || s_ypos != CW'(reqrows - 1)) pos_bad++;
                xc++;
            end
            if (s_de && !prev_de) begin
                rows++;
                if (n - t_req != S_LEAD) lead_bad++;
            end
            if (s_rgb !== (s_de ? pix_s : 24'h0)) rgb_bad++;
            prev_req = s_req;
            prev_de  = s_de;
            step();
            n++;
        end while (!s_fs && n < 2000);
        check({tag, "_active_mode"}, {31'd0, m}, {31'd0, v.mode});
        check({tag, "_frame_clocks"}, n, v.clocks);
        check({tag, "_lines"}, lines, v.lines);
        check({tag, "_de_clocks"}, de, v.de);
        check({tag, "_active_rows"}, rows, v.rows);
        check({tag, "_hs_clocks"}, hs, v.hs);
        check({tag, "_vs_clocks"}, vs, v.vs);
        check({tag, "_h_disp"}, {20'd0, hd}, v.hd);
        check({tag, "_v_disp"}, {20'd0, vd}, v.vd);
        check({tag, "_hs_at_line_start"}, hs_miss, 0);
        check({tag, "_req_lead"}, lead_bad, 0);
        check({tag, "_xy_pos"}, pos_bad, 0);
        check({tag, "_rgb"}, rgb_bad, 0);
    endtask

    prof_vec_t vecs [4];

    initial begin
        int unsigned n, hs_low, vs_low, t, xc, decnt, de_first, xbad, rgbbad, px, early;
        logic [CW-1:0] y_first;
        logic [23:0] r0, r100, r700;
        logic prev_mode;

        vecs[0] = '{1'b0, 560, 14, 120, 6, 112, 80, 20, 6};
        vecs[1] = '{1'b1, 216,  9,  48, 4,  36, 24, 12, 4};
        vecs[2] = '{1'b0, 560, 14, 120, 6, 112, 80, 20, 6};
        vecs[3] = '{1'b1, 216,  9,  48, 4,  36, 24, 12, 4};

        #1;
        rst_a = 1'b1;
        rst_s = 1'b1;
        repeat (3) step();
        check("a_reset_ctl", {27'd0, a_req, a_de, a_fs, a_ls, a_mode}, 0);
        check("a_reset_sync_idle", {30'd0, a_hs, a_vs}, 3);
        check("a_reset_pos", {8'd0, a_xpos, a_ypos}, 0);
        check("s_reset_ctl", {27'd0, s_req, s_de, s_fs, s_ls, s_mode}, 0);
        check("s_reset_sync_idle", {30'd0, s_hs, s_vs}, 0);
        check("reset_bl_rst_rgb", {28'd0, a_bl, a_rst, s_bl, s_rst}, 4'b1010);
        check("reset_rgb", a_rgb | s_rgb, 0);
        check("lcd_clk_low", {30'd0, a_clk, s_clk}, 0);

        rst_a = 1'b0;
        rst_s = 1'b0;
        step();
        check("a_first_frame_start", {30'd0, a_fs, a_ls}, 3);
        check("lcd_rst_released", {30'd0, a_rst, s_rst}, 3);
        check("a_disp_profile0", {8'd0, a_hd, a_vd}, {8'd0, 12'd800, 12'd480});

        // Default instance: first three lines for line length and sync widths.
        hs_low = 0;
        vs_low = 0;
        for (int l = 0; l < 3; l++) begin
            n = 0;
            do begin
                if (l == 0 && !a_hs) hs_low++;
                if (!a_vs) vs_low++;
                step();
                n++;
            end while (!a_ls && n < 2000);
            check($sformatf("a_line%0d_clocks", l), n, 1056);
        end
        check("a_hs_low_clocks", hs_low, 128);
        check("a_vs_low_clocks", vs_low, 2 * 1056);

        // Default instance: first active line.
        n = 0;
        while (!a_req && n < 40000) begin
            step();
            n++;
        end
        check("a_first_req_seen", {31'd0, a_req}, 1);
        y_first = a_ypos;
        t = 0; xc = 0; decnt = 0; xbad = 0; rgbbad = 0; de_first = 9999;
        do begin
            if (a_req) begin
                if (a_xpos != CW'(xc)) xbad++;
                xc++;
            end
            if (a_de) begin
                decnt++;
                if (de_first == 9999) de_first = t;
            end
            if (a_rgb !== (a_de ? pix_a : 24'h0)) rgbbad++;
            step();
            t++;
        end while (!a_ls && t < 1200);
        check("a_first_active_ypos", {20'd0, y_first}, 0);
        check("a_req_lead", de_first, 2);
        check("a_req_count", xc, 800);
        check("a_de_count", decnt, 800);
        check("a_xpos_seq", xbad, 0);
        check("a_rgb_passthrough", rgbbad, 0);

        // Default instance: next active line with the colour-bar select raised.
        tp_a = 1'b1;
        n = 0;
        while (!a_de && n < 1200) begin
            step();
            n++;
        end
        check("a_pattern_de_seen", {31'd0, a_de}, 1);
        px = 0; rgbbad = 0; r0 = '0; r100 = '0; r700 = '0;
        while (a_de && px < 1000) begin
            if (a_rgb !== pat_exp(px)) rgbbad++;
            if (px == 0)   r0   = a_rgb;
            if (px == 100) r100 = a_rgb;
            if (px == 700) r700 = a_rgb;
            step();
            px++;
        end
        tp_a = 1'b0;
        check("a_pattern_width", px, 800);
        check("a_pattern_px0", r0, pat_exp(0));
        check("a_pattern_px100", r100, pat_exp(100));
        check("a_pattern_px700", r700, pat_exp(700));
        check("a_pattern_all", rgbbad, 0);

        // Scaled instance: profile switching table.
        prev_mode = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_fs_s();
            repeat (100) step();
            mode_s = vecs[i].mode;
            early = 0;
            n = 0;
            while (!s_fs && n < 1000) begin
                if (s_mode != prev_mode) early++;
                step();
                n++;
            end
            check($sformatf("vec%0d_no_early_switch", i), early, 0);
            measure(vecs[i], $sformatf("vec%0d", i));
            prev_mode = vecs[i].mode;
        end

        // Scaled instance: asynchronous reset in the middle of an active line.
        repeat (130) step();
        check("s_pre_reset_active", {29'd0, s_req, s_de, s_mode}, 3'b111);
        #2 rst_s = 1'b1;
        #1;
        check("s_async_reset_ctl", {27'd0, s_req, s_de, s_fs, s_ls, s_mode}, 0);
        check("s_async_reset_sync", {30'd0, s_hs, s_vs}, 0);
        check("s_async_reset_pos", {8'd0, s_xpos, s_ypos}, 0);
        check("s_async_reset_disp", {8'd0, s_hd, s_vd}, {8'd0, 12'd20, 12'd6});
        check("s_async_reset_rgb", s_rgb, 0);
        mode_s = 1'b0;
        step();
        rst_s = 1'b0;
        step();
        check("s_frame_start_after_reset", {31'd0, s_fs}, 1);
        measure(vecs[0], "post_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
